// File: rtl/cpu_pkg.sv
// Shared definitions for the stack CPU: fetch FSM state encoding,
// default reset PC and instruction-memory sizing.
package cpu_pkg;

    typedef enum logic [1:0] {
        FS_RUN    = 2'd0,
        FS_HALTED = 2'd1,
        FS_FAULT  = 2'd2
    } fetch_state_t;

    localparam int unsigned CPU_ABITS    = 32;
    localparam int unsigned CPU_RESET_PC = 0;

    // Instruction memory holds a quarter of the address space, in words.
    localparam longint unsigned IMEM_WORDS = 64'd1 << (CPU_ABITS - 2);

    // Instruction-memory word count for an arbitrary address width.
    function automatic longint unsigned imem_words(input int unsigned abits);
        return 64'd1 << (abits - 2);
    endfunction

endpackage

// File: rtl/pc_reg.sv
// Program counter register with load (redirect), increment and hold.
// Load takes priority over increment; with neither asserted the PC holds.
module pc_reg
    import cpu_pkg::*;
#(
    parameter int unsigned ABITS    = CPU_ABITS,
    parameter int unsigned RESET_PC = CPU_RESET_PC
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [ABITS-1:0] load_pc,
    input  logic             inc,
    output logic [ABITS-1:0] pc
);

    logic [ABITS-1:0] pc_q;
    logic [ABITS-1:0] pc_d;

    // Next-PC selection: redirect target, sequential increment, or hold.
    always_comb begin
        pc_d = pc_q;
        if (load) begin
            pc_d = load_pc;
        end else if (inc) begin
            pc_d = pc_q + {{(ABITS-1){1'b0}}, 1'b1};
        end
    end

    // PC register; reset returns to the configured boot address.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= ABITS'(RESET_PC);
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: drives the combinational-read instruction memory,
// captures each word into a one-entry instruction register offered to the
// decoder over valid/ready, and handles redirect, halt and PC range fault.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int unsigned ABITS    = CPU_ABITS,
    parameter int unsigned DBITS    = 32,
    parameter int unsigned RESET_PC = CPU_RESET_PC
) (
    input  logic             clk,
    input  logic             rst,
    output logic             imem_en,
    output logic [ABITS-1:0] imem_addr,
    input  logic [DBITS-1:0] imem_data,
    input  logic             dec_ready,
    input  logic             redirect_valid,
    input  logic [ABITS-1:0] redirect_pc,
    input  logic             halt_req,
    output logic [DBITS-1:0] instr,
    output logic [ABITS-1:0] instr_pc,
    output logic             instr_valid,
    output logic             halted,
    output logic             fault,
    output logic [31:0]      fetch_count
);

    fetch_state_t     state_q, state_d;
    logic [DBITS-1:0] instr_q, instr_d;
    logic [ABITS-1:0] instr_pc_q, instr_pc_d;
    logic             instr_valid_q, instr_valid_d;
    logic [31:0]      fetch_count_q, fetch_count_d;

    logic [ABITS-1:0] pc;
    logic             pc_load;
    logic             pc_inc;

    logic is_run;
    logic take;
    logic slot_free;
    logic in_range;
    logic fetch;

    pc_reg #(
        .ABITS    (ABITS),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk     (clk),
        .rst     (rst),
        .load    (pc_load),
        .load_pc (redirect_pc),
        .inc     (pc_inc),
        .pc      (pc)
    );

    // The memory spans 2^(ABITS-2) words, so a PC is in range exactly when
    // its top two bits are clear.
    assign in_range  = (pc[ABITS-1 -: 2] == 2'b00);
    assign is_run    = (state_q == FS_RUN);
    assign take      = instr_valid_q & dec_ready;
    assign slot_free = ~instr_valid_q | dec_ready;
    assign fetch     = is_run & slot_free & ~redirect_valid & ~halt_req & in_range;

    // Reset gates the enable combinationally so it drops without a clock.
    assign imem_en   = fetch & ~rst;
    assign imem_addr = pc;

    // Next-state and datapath control; halt beats redirect beats fetch,
    // and a fault is only raised once the instruction slot has drained.
    always_comb begin
        state_d       = state_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        instr_valid_d = instr_valid_q;
        fetch_count_d = fetch_count_q;
        pc_load       = 1'b0;
        pc_inc        = 1'b0;
        if (is_run) begin
            if (halt_req) begin
                state_d       = FS_HALTED;
                instr_valid_d = 1'b0;
            end else if (redirect_valid) begin
                pc_load       = 1'b1;
                instr_valid_d = 1'b0;
            end else if (fetch) begin
                instr_d       = imem_data;
                instr_pc_d    = pc;
                instr_valid_d = 1'b1;
                pc_inc        = 1'b1;
                fetch_count_d = fetch_count_q + 32'd1;
            end else if (slot_free && !in_range) begin
                state_d       = FS_FAULT;
                instr_valid_d = 1'b0;
            end else if (take) begin
                instr_valid_d = 1'b0;
            end
        end
    end

    // State, instruction register and fetch counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= FS_RUN;
            instr_q       <= '0;
            instr_pc_q    <= '0;
            instr_valid_q <= 1'b0;
            fetch_count_q <= '0;
        end else begin
            state_q       <= state_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = instr_valid_q;
    assign halted      = (state_q == FS_HALTED);
    assign fault       = (state_q == FS_FAULT);
    assign fetch_count = fetch_count_q;

endmodule
